// File: rtl/player_move_ctrl.sv
// player_move_ctrl: per-frame player movement with map-bounds check and collision-RAM corner probing.
// Define PLAYER_COLLISION_EN to probe the collision RAM; otherwise in-bounds moves commit one cycle after acceptance.
module player_move_ctrl #(
    parameter int MAP_W   = 320,
    parameter int MAP_H   = 240,
    parameter int SPR_W   = 16,
    parameter int SPR_H   = 16,
    parameter int STEP    = 1,
    parameter int START_X = 152,
    parameter int START_Y = 112
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        dir_valid,
    input  logic [1:0]  dir,
    output logic [18:0] coll_addr,
    input  logic        coll_data,
    output logic [8:0]  pos_x,
    output logic [7:0]  pos_y,
    output logic [1:0]  facing,
    output logic        moving,
    output logic        blocked,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, PROBE, DRAIN, COMMIT} state_t;
`ifdef PLAYER_COLLISION_EN
    localparam state_t FIRST = PROBE;
`else
    localparam state_t FIRST = COMMIT;
`endif
    state_t             state_q, state_d;
    logic [8:0]         pos_x_q, pos_x_d, cx_q, cx_d;
    logic [7:0]         pos_y_q, pos_y_d, cy_q, cy_d;
    logic [1:0]         facing_q, facing_d, cnt_q, cnt_d;
    logic               moving_q, moving_d, blocked_q, blocked_d, busy_q, busy_d, hit_q, hit_d;
    logic [18:0]        coll_addr_q, coll_addr_d;
    logic signed [11:0] cand_x, cand_y;
    logic               oob, start;

    // Candidate is kept wide and signed so an underflow shows up as negative instead of wrapping.
    always_comb begin
        cand_x = $signed({3'b0, pos_x_q}) + $signed(dir == 2'd3 ? 12'(STEP) : dir == 2'd2 ? -12'(STEP) : 12'd0);
        cand_y = $signed({4'b0, pos_y_q}) + $signed(dir == 2'd1 ? 12'(STEP) : dir == 2'd0 ? -12'(STEP) : 12'd0);
        oob = cand_x < 12'sd0 || cand_y < 12'sd0 ||
              cand_x + $signed(12'(SPR_W)) > $signed(12'(MAP_W)) ||
              cand_y + $signed(12'(SPR_H)) > $signed(12'(MAP_H));
        start = state_q == IDLE && frame_tick && dir_valid && !oob;
    end

    always_comb begin
        state_d   = state_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        facing_d  = facing_q;
        cnt_d     = cnt_q;
        moving_d  = moving_q;
        blocked_d = 1'b0;
        busy_d    = busy_q;
        hit_d     = hit_q;
        if (state_q == IDLE && frame_tick) begin
            moving_d  = 1'b0;
            facing_d  = dir_valid ? dir : facing_q;
            blocked_d = dir_valid && oob;
            if (start) begin
                cx_d    = cand_x[8:0];
                cy_d    = cand_y[7:0];
                hit_d   = 1'b0;
                cnt_d   = 2'd0;
                busy_d  = 1'b1;
                state_d = FIRST;
            end
        end
`ifdef PLAYER_COLLISION_EN
        // RAM data trails its address by one cycle, so the first probe cycle has nothing to sample yet.
        else if (state_q == PROBE) begin
            cnt_d   = cnt_q + 2'd1;
            hit_d   = hit_q | (coll_data & (cnt_q != 2'd0));
            state_d = cnt_q == 2'd3 ? DRAIN : PROBE;
        end else if (state_q == DRAIN) begin
            hit_d   = hit_q | coll_data;
            state_d = COMMIT;
        end
`endif
        else if (state_q == COMMIT) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            moving_d  = !hit_q;
            blocked_d = hit_q;
            pos_x_d   = hit_q ? pos_x_q : cx_q;
            pos_y_d   = hit_q ? pos_y_q : cy_q;
        end
    end

`ifdef PLAYER_COLLISION_EN
    logic [1:0]  ci;
    logic [18:0] ax, ay;
    always_comb begin
        ci = state_q == IDLE ? 2'd0 : cnt_q + 2'd1;
        ax = 19'(state_q == IDLE ? cand_x[8:0] : cx_q) + (ci[0] ? 19'(SPR_W - 1) : 19'd0);
        ay = 19'(state_q == IDLE ? cand_y[7:0] : cy_q) + (ci[1] ? 19'(SPR_H - 1) : 19'd0);
        coll_addr_d = (start || (state_q == PROBE && cnt_q != 2'd3)) ? ay * 19'(MAP_W) + ax : coll_addr_q;
    end
`else
    logic unused_coll;
    assign unused_coll = coll_data;
    assign coll_addr_d = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            pos_x_q     <= 9'(START_X);
            pos_y_q     <= 8'(START_Y);
            cx_q        <= '0;
            cy_q        <= '0;
            facing_q    <= 2'd1;
            cnt_q       <= '0;
            moving_q    <= 1'b0;
            blocked_q   <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
            coll_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            facing_q    <= facing_d;
            cnt_q       <= cnt_d;
            moving_q    <= moving_d;
            blocked_q   <= blocked_d;
            busy_q      <= busy_d;
            hit_q       <= hit_d;
            coll_addr_q <= coll_addr_d;
        end
    end

    assign coll_addr = coll_addr_q;
    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign facing    = facing_q;
    assign moving    = moving_q;
    assign blocked   = blocked_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: scoreboard bench; a position/map model predicts each request's outcome,
// a monitor pops predictions whenever the controller finishes or rejects a request.
module tb_player_move_ctrl;
    localparam int MW = 320, MH = 240, SW = 16, SH = 16;
`ifdef PLAYER_COLLISION_EN
    localparam int LAT  = 6;
    localparam bit COLL = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit COLL = 1'b0;
`endif
    typedef struct { int x; int y; int f; int mv; int bl; int cyc; } exp_t;

    logic        Clk = 0, Reset = 1, frame_tick = 0, dir_valid = 0, coll_data = 0;
    logic [1:0]  dir = 0;
    logic [18:0] coll_addr;
    logic [8:0]  pos_x;
    logic [7:0]  pos_y;
    logic [1:0]  facing;
    logic        moving, blocked, busy;

    bit   mem [MW*MH];
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0, n_chk = 0, n_fail = 0;
    int   mx = 152, my = 112, free_cyc = 0, saved_addr = 0;
    bit   mmov = 0, busy_prev = 0;

    player_move_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .dir_valid(dir_valid), .dir(dir),
        .coll_addr(coll_addr), .coll_data(coll_data), .pos_x(pos_x), .pos_y(pos_y),
        .facing(facing), .moving(moving), .blocked(blocked), .busy(busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;
    always @(posedge Clk) coll_data <= (int'(coll_addr) < MW*MH) ? mem[coll_addr] : 1'b0;

    function automatic void check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit hit_at(input int x, input int y);
        return mem[y*MW + x] | mem[y*MW + x + SW - 1] | mem[(y + SH - 1)*MW + x] | mem[(y + SH - 1)*MW + x + SW - 1];
    endfunction

    // Model evaluation of one tick at the current negedge, then drive it.
    task automatic drive(input int d, input bit v, input bit rec);
        exp_t e;
        int nx, ny;
        if (cyc >= free_cyc) begin
            check("idle_busy", busy, 0);
            check("idle_pos_x", pos_x, mx);
            check("idle_pos_y", pos_y, my);
            check("idle_moving", moving, mmov);
            mmov = 0;
            if (v) begin
                nx = mx + (d == 3 ? 1 : d == 2 ? -1 : 0);
                ny = my + (d == 1 ? 1 : d == 0 ? -1 : 0);
                if (nx < 0 || ny < 0 || nx + SW > MW || ny + SH > MH) begin
                    e = '{mx, my, d, 0, 1, cyc + 1};
                    free_cyc = cyc + 1;
                end else if (COLL && hit_at(nx, ny)) begin
                    e = '{mx, my, d, 0, 1, cyc + 1 + LAT};
                    free_cyc = cyc + 1 + LAT;
                end else begin
                    mx = nx;
                    my = ny;
                    mmov = 1;
                    e = '{nx, ny, d, 1, 0, cyc + 1 + LAT};
                    free_cyc = cyc + 1 + LAT;
                end
                if (rec) sb.push_back(e);
            end
        end
        frame_tick = 1;
        dir = 2'(d);
        dir_valid = v;
    endtask

    task automatic req(input int d, input bit v, input bit rec, input int hold);
        @(negedge Clk);
        for (int i = 0; i < hold; i++) begin
            drive(d, v, rec);
            @(negedge Clk);
        end
        frame_tick = 0;
        dir = 2'($urandom);
        dir_valid = 1'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc < free_cyc) @(negedge Clk);
    endtask

    task automatic do_reset();
        check("pending_before_reset", sb.size(), 0);
        Reset = 1;
        frame_tick = 0;
        dir_valid = 0;
        @(negedge Clk);
        check("rst_pos_x", pos_x, 152);
        check("rst_pos_y", pos_y, 112);
        check("rst_facing", facing, 1);
        check("rst_busy", busy, 0);
        check("rst_blocked", blocked, 0);
        check("rst_moving", moving, 0);
        check("rst_coll_addr", coll_addr, 0);
        @(negedge Clk);
        Reset = 0;
        mx = 152;
        my = 112;
        mmov = 0;
        free_cyc = 0;
    endtask

    // Monitor: a response is a blocked pulse or the end of an evaluation.
    always @(posedge Clk) begin
        #1;
        if (!Reset && (blocked || (busy_prev && !busy))) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_response: blocked=%0d pos=(%0d,%0d), expected no response (cycle %0d)", blocked, pos_x, pos_y, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("resp_cycle", cyc, mon_e.cyc);
                check("resp_pos_x", pos_x, mon_e.x);
                check("resp_pos_y", pos_y, mon_e.y);
                check("resp_facing", facing, mon_e.f);
                check("resp_moving", moving, mon_e.mv);
                check("resp_blocked", blocked, mon_e.bl);
                check("resp_busy", busy, 0);
`ifndef PLAYER_COLLISION_EN
                check("resp_coll_addr_tied", coll_addr, 0);
`endif
            end
        end
        busy_prev = busy & !Reset;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge Clk);
        do_reset();
`ifdef PLAYER_COLLISION_EN
        req(3, 1, 1, 1);
        check("probe_corner0", coll_addr, 112*320 + 153);
        @(negedge Clk);
        check("probe_corner1", coll_addr, 112*320 + 168);
        @(negedge Clk);
        check("probe_corner2", coll_addr, 127*320 + 153);
        @(negedge Clk);
        check("probe_corner3", coll_addr, 127*320 + 168);
        wait_idle();
        do_reset();
        mem[127*320 + 168] = 1;
        req(3, 1, 1, 1);
        wait_idle();
        mem[127*320 + 168] = 0;
        do_reset();
`else
        for (int i = 0; i < MW*MH; i++) mem[i] = 1;
        req(1, 1, 1, 1);
        check("tied_coll_addr", coll_addr, 0);
        wait_idle();
`endif
        for (int i = 0; i < 400 && mx > 0; i++) begin wait_idle(); req(2, 1, 1, 1); end
        for (int i = 0; i < 400 && my > 50; i++) begin wait_idle(); req(0, 1, 1, 1); end
        wait_idle();
        saved_addr = coll_addr;
        req(2, 1, 1, 1);
        check("left_reject_busy", busy, 0);
        @(negedge Clk);
        check("left_reject_no_probe", coll_addr, saved_addr);
        for (int i = 0; i < 400 && mx < MW - SW; i++) begin wait_idle(); req(3, 1, 1, 1); end
        wait_idle();
        saved_addr = coll_addr;
        req(3, 1, 1, 1);
        check("right_reject_busy", busy, 0);
        @(negedge Clk);
        check("right_reject_no_probe", coll_addr, saved_addr);
        for (int i = 0; i < 400 && my < MH - SH; i++) begin wait_idle(); req(1, 1, 1, 1); end
        wait_idle();
        req(1, 1, 1, 1);
        for (int i = 0; i < 400 && my > 0; i++) begin wait_idle(); req(0, 1, 1, 1); end
        wait_idle();
        req(0, 1, 1, 1);
        wait_idle();
        req(1, 1, 1, 2);
        wait_idle();
        req(2, 1, 1, 1);
        req(3, 1, 1, 1);
        wait_idle();
        req(1, 1, 0, 1);
        repeat (COLL ? 2 : 0) @(negedge Clk);
        do_reset();
        for (int i = 0; i < MW*MH; i++) mem[i] = COLL ? ($urandom_range(0, 63) == 0) : 1'($urandom);
        repeat (300) begin
            repeat ($urandom_range(0, 6)) @(negedge Clk);
            req($urandom_range(0, 3), $urandom_range(0, 7) != 0, 1, $urandom_range(1, 2));
        end
        wait_idle();
        repeat (4) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Player movement controller for the overworld. Once per frame it takes a direction request and computes the candidate sprite position. It then probes the four footprint corners in the collision RAM through that RAM's read port (1-cycle registered read) and commits the move only if every probed pixel is walkable. Its outputs feed the sprite/map compositor (character origin, facing, moving flag).

## Interface
Parameters:
- MAP_W, 320, map width in pixels
- MAP_H, 240, map height in pixels
- SPR_W, 16, character footprint width
- SPR_H, 16, character footprint height
- STEP, 1, pixels moved per accepted request
- START_X, 152, reset x position
- START_Y, 112, reset y position

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- dir_valid  in  1  a direction key is held
- dir  in  2  0 up, 1 down, 2 left, 3 right
- coll_addr  out  19  collision RAM read address, y*MAP_W+x
- coll_data  in  1  collision RAM data_Out; 1 = blocked
- pos_x  out  9  sprite top-left x
- pos_y  out  8  sprite top-left y
- facing  out  2  last requested direction, same encoding as dir
- moving  out  1  high for the frame after a committed move
- blocked  out  1  one-cycle pulse when a request is rejected
- busy  out  1  evaluation in progress

## Operation
- Reset values: pos_x=START_X, pos_y=START_Y, facing=1 (down), moving=0, blocked=0, busy=0, coll_addr=0, state IDLE.
- States: IDLE, PROBE, DRAIN, COMMIT.
- IDLE: when frame_tick=1 and dir_valid=1:
  - latch dir into facing;
  - compute candidate (cx,cy) = pos ± STEP on the selected axis;
  - go to PROBE with busy=1.
- IDLE, frame_tick=1 with dir_valid=0: moving cleared, nothing else changes.
- Bounds: the candidate is rejected immediately (blocked pulse, no probing, facing still updated, position unchanged) when any of these hold:
  - cx<0 or cy<0 (up or left underflow);
  - cx+SPR_W>MAP_W;
  - cy+SPR_H>MAP_H.
  Bounds are checked on widened signed arithmetic, never after wrap.
- PROBE: issue corners k=0..3 in order: (cx,cy), (cx+SPR_W-1,cy), (cx,cy+SPR_H-1), (cx+SPR_W-1,cy+SPR_H-1). Address = cy_k*MAP_W+cx_k, computed at 19 bits (max 76799).
- Result: coll_data is OR-accumulated into a hit flag, each sample one cycle after its address.
- DRAIN: collects the final sample.
- COMMIT, hit=0: pos ← candidate, moving=1.
- COMMIT, hit=1: position held, moving=0, blocked pulses.
- COMMIT returns to IDLE.
- frame_tick during busy=1 is ignored, not queued.
- Reset mid-evaluation: aborts with no commit; all outputs take their reset values.
- dir and dir_valid are sampled only at acceptance; later changes do not affect the evaluation.

## Timing
- E0 = the edge that accepts a request.
- After E0: busy=1, coll_addr=corner0.
- After E1, E2, E3: coll_addr = corner1, corner2, corner3.
- coll_data sampled at E2..E5.
- pos_x, pos_y, moving, blocked update after E6; busy=0 after E6.
- Total latency: 6 cycles.
- Bounds rejection: blocked=1 for exactly the cycle after E0; busy stays 0.
- coll_addr holds its last value in IDLE.
- moving stays high until the next frame_tick.

## Configuration
- PLAYER_COLLISION_EN defined: behaviour as above.
- PLAYER_COLLISION_EN undefined:
  - no probing; coll_data ignored and coll_addr tied to 0;
  - an in-bounds request commits after E1 (latency 1);
  - busy is high only between E0 and E1;
  - blocked asserts only on bounds rejection.

## Test plan
- Reset, then idle: pos=(152,112), facing=1, busy=0, coll_addr=0, blocked=0.
- Collision RAM all zeros; frame_tick with dir=3: coll_addr sequence 112*320+153, 112*320+168, 127*320+153, 127*320+168 on consecutive cycles; pos_x=153 six cycles after E0; moving=1.
- Set the word at 127*320+168 to 1; repeat dir=3: blocked pulses at E6, pos_x stays 152, facing=3, moving=0.
- Place player at (0,50); request dir=2: blocked the cycle after E0, no probes, pos unchanged. Same check at x=304 with dir=3.
- Assert frame_tick again at E2 of an evaluation: ignored, exactly one commit. Assert Reset at E3: pos returns to (152,112), busy=0, no commit.
- PLAYER_COLLISION_EN undefined; collision RAM all ones; request dir=1: pos_y=113 after E1, coll_addr stays 0.
